// File: rtl/muldiv_hilo.sv
// muldiv_hilo: execute-stage multiply/divide unit with the HI/LO register pair.
// mult/multu/div/divu run iteratively (one bit per cycle, plus a sign-fixup cycle).
// mfhi/mflo are served combinationally, and mthi/mtlo write directly.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle using a
// combinational product. Divides stay iterative.
module muldiv_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             HI_LO_write,
    input  logic [5:0]       Function_opcode,
    input  logic [1:0]       HI_LO_move,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;      // mult: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     opnd;     // mult: multiplicand magnitude; div: divisor magnitude
    logic                 op_div;
    logic                 neg_res;  // operand signs differ (signed ops only)
    logic                 neg_rem;  // dividend was negative (signed ops only)
    logic                 div0;

    // decode of the incoming operation
    logic                 op_sgn, op_div_in, a_neg_in, b_neg_in;
    logic [WIDTH-1:0]     a_mag_in, b_mag_in;
    logic                 fast_hit;
    logic [2*WIDTH-1:0]   fast_prod;

    // per-iteration datapath
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quot, rem;

    logic                 unused_ok;
    assign unused_ok = ^{Function_opcode[5:2], div_diff[WIDTH]};

    // operand magnitudes and sign flags for the operation being issued
    always_comb begin
        op_sgn    = ~Function_opcode[0];
        op_div_in = Function_opcode[1];
        a_neg_in  = op_sgn & rs_data[WIDTH-1];
        b_neg_in  = op_sgn & rt_data[WIDTH-1];
        a_mag_in  = a_neg_in ? (~rs_data + 1'b1) : rs_data;
        b_mag_in  = b_neg_in ? (~rt_data + 1'b1) : rt_data;
    end

`ifdef MULDIV_FAST_MUL_EN
    // single-cycle multiply: magnitude product, negated when signs differ
    always_comb begin
        fast_hit  = ~Function_opcode[1];
        fast_prod = {{WIDTH{1'b0}}, a_mag_in} * {{WIDTH{1'b0}}, b_mag_in};
        if (a_neg_in ^ b_neg_in)
            fast_prod = ~fast_prod + 1'b1;
    end
`else
    // every operation takes the iterative path
    always_comb begin
        fast_hit  = 1'b0;
        fast_prod = '0;
    end
`endif

    // one shift-add or restoring-divide step, plus the final sign fixup values
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, opnd};
        div_ok   = ~div_diff[WIDTH+1];
        if (op_div)
            step = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
        else
            step = {mul_sum, acc[WIDTH-1:1]};
        mul_res = neg_res ? (~acc + 1'b1) : acc;
        quot    = div0 ? '1 : (neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
        rem     = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // state register
    always_ff @(posedge clock) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: start -> 32 iterations -> one fixup edge -> idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (HI_LO_write && !fast_hit) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath, counter and HI/LO registers
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            HI      <= '0;
            LO      <= '0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (HI_LO_write) begin
                        if (fast_hit) begin
                            HI <= fast_prod[2*WIDTH-1:WIDTH];
                            LO <= fast_prod[WIDTH-1:0];
                        end else begin
                            cnt     <= '0;
                            op_div  <= op_div_in;
                            neg_res <= a_neg_in ^ b_neg_in;
                            neg_rem <= a_neg_in;
                            div0    <= (rt_data == '0);
                            opnd    <= op_div_in ? b_mag_in : a_mag_in;
                            acc     <= {{WIDTH{1'b0}}, (op_div_in ? a_mag_in : b_mag_in)};
                        end
                    end else begin
                        // mthi/mtlo share rs_data; both may fire together
                        if (mthi) HI <= rs_data;
                        if (mtlo) LO <= rs_data;
                    end
                end
                RUN: begin
                    acc <= step;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (op_div) begin
                        HI <= rem;
                        LO <= quot;
                    end else begin
                        HI <= mul_res[2*WIDTH-1:WIDTH];
                        LO <= mul_res[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // busy/stall and the mfhi/mflo read port (committed HI/LO only)
    always_comb begin
        busy  = (state != IDLE);
        stall = busy & (HI_LO_write | (HI_LO_move != 2'b00) | mthi | mtlo);
        case (HI_LO_move)
            2'b10:   hilo_rdata = HI;
            2'b01:   hilo_rdata = LO;
            default: hilo_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_n;
    logic        HI_LO_write;
    logic [5:0]  Function_opcode;
    logic [1:0]  HI_LO_move;
    logic        mthi, mtlo;
    logic [31:0] rs_data, rt_data;
    logic [31:0] hilo_rdata, HI, LO;
    logic        busy, stall;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    muldiv_hilo dut (
        .clock(clock), .rst_n(rst_n), .HI_LO_write(HI_LO_write),
        .Function_opcode(Function_opcode), .HI_LO_move(HI_LO_move),
        .mthi(mthi), .mtlo(mtlo), .rs_data(rs_data), .rt_data(rt_data),
        .hilo_rdata(hilo_rdata), .HI(HI), .LO(LO), .busy(busy), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // reference result {HI, LO} from plain arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib, q, r;
        logic [63:0] res;
        case (op)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                res = 64'(sa * sb);
            end
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    ia = a; ib = b;
                    q = ia / ib; r = ia % ib;
                    res = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // behavioural model: result computed at issue, committed 33 edges later
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_cnt;
    always @(posedge clock) begin
        if (!rst_n) begin
            m_hi <= 32'h0; m_lo <= 32'h0; m_cnt <= 0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin m_hi <= p_hi; m_lo <= p_lo; end
            m_cnt <= m_cnt - 1;
        end else if (HI_LO_write) begin
            if (FAST && !Function_opcode[1]) begin
                {m_hi, m_lo} <= ref_res(Function_opcode[1:0], rs_data, rt_data);
            end else begin
                {p_hi, p_lo} <= ref_res(Function_opcode[1:0], rs_data, rt_data);
                m_cnt <= 33;
            end
        end else begin
            if (mthi) m_hi <= rs_data;
            if (mtlo) m_lo <= rs_data;
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
            check("stall", {31'b0, stall},
                  {31'b0, (m_cnt != 0) && (HI_LO_write || HI_LO_move != 2'b00 || mthi || mtlo)});
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
            check("hilo_rdata", hilo_rdata,
                  (HI_LO_move == 2'b10) ? m_hi : (HI_LO_move == 2'b01) ? m_lo : 32'h0);
        end
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        HI_LO_write = 1'b1; Function_opcode = {4'b0110, op}; rs_data = a; rt_data = b;
        tick;
        HI_LO_write = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin tick; n++; end
        if (n >= 100) check("busy_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        start_op(op, a, b);
        wait_idle(n);
        check({name, "_cycles"}, n, (FAST && !op[1]) ? 32'd0 : 32'd33);
        check({name, "_HI"}, HI, ehi);
        check({name, "_LO"}, LO, elo);
    endtask

    logic [1:0]  t_op [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
    logic [31:0] t_a  [4] = '{32'h1234_5678, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0064};
    logic [31:0] t_b  [4] = '{32'h9ABC_DEF0, 32'h8000_0000, 32'h0000_0010, 32'hFFFF_FFF9};

    initial begin
        int n;
        rst_n = 1'b0; HI_LO_write = 1'b0; Function_opcode = 6'h0; HI_LO_move = 2'b00;
        mthi = 1'b0; mtlo = 1'b0; rs_data = 32'h0; rt_data = 32'h0;
        tick; tick;
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_HI", HI, 32'h0);
        check("reset_LO", LO, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'h0000_0007, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // mflo and mthi held during a divide
        start_op(2'b10, 32'd100, 32'd7);
        repeat (5) tick;
        HI_LO_move = 2'b01; mthi = 1'b1; rs_data = 32'h0000_1234;
        #1;
        check("stall_mflo", {31'b0, stall}, 32'h1);
        wait_idle(n);
        check("stall_after", {31'b0, stall}, 32'h0);
        check("mflo_new", hilo_rdata, 32'd14);
        check("mthi_ignored", HI, 32'd2);
        tick;
        check("mthi_retry", HI, 32'h0000_1234);
        HI_LO_move = 2'b00; mthi = 1'b0;

        // reset in the middle of an iteration
        start_op(2'b11, 32'hFFFF_0000, 32'h0000_0003);
        repeat (9) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_HI", HI, 32'h0);
        check("rst_LO", LO, 32'h0);
        rs_data = 32'h0000_ABCD; mthi = 1'b1;
        tick;
        mthi = 1'b0; HI_LO_move = 2'b10;
        #1;
        check("mfhi_abcd", hilo_rdata, 32'h0000_ABCD);
        HI_LO_move = 2'b00;

        // start and mtlo together: start wins
        rs_data = 32'h0000_5555; mtlo = 1'b1;
        tick;
        HI_LO_write = 1'b1; Function_opcode = 6'h1B; rs_data = 32'd9; rt_data = 32'd2;
        tick;
        HI_LO_write = 1'b0; mtlo = 1'b0;
        check("mtlo_dropped", LO, 32'h0000_5555);
        check("start_busy", {31'b0, busy}, 32'h1);
        wait_idle(n);
        check("divu9_cycles", n, 32'd33);
        check("divu9_LO", LO, 32'd4);
        check("divu9_HI", HI, 32'd1);
        // back-to-back on the first idle cycle
        run_op("b2b_mult", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);

        for (int i = 0; i < 4; i++) begin
            logic [63:0] e;
            e = ref_res(t_op[i], t_a[i], t_b[i]);
            run_op("table", t_op[i], t_a[i], t_b[i], e[63:32], e[31:0]);
        end

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
